hazard_stall_ctrl: RTL and testbench
====================================

Name: hazard_stall_ctrl

Overview:
Central stall/flush sequencer for the 5-stage pipeline.
- Detects load-use hazards between ID and EXE and handles taken branches and jumps resolved in ID.
- Freezes the pipeline while data memory is busy.
- Drives the write-enable, flush and bubble controls of PC, IF_ID and ID_EXE, and the freeze of EXE_MEM/MEM_WB.
- Keeps saturating stall/flush performance counters and a sticky memory-timeout flag.

Parameters:
CNT_W, 16, width of stall_count and flush_count
MEM_TIMEOUT, 64, consecutive mem_busy cycles that set mem_timeout (>=1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
ID_reg_address_rs  in  5  rs field of the instruction in ID
ID_reg_address_rt  in  5  rt field of the instruction in ID
ID_uses_rt  in  1  instruction in ID reads rt as a source
EXE_mem_read  in  1  instruction in EXE is a load
EXE_reg_address_rt  in  5  load destination register in EXE
branch_taken  in  1  branch in ID resolved taken
jump  in  1  jump in ID
mem_busy  in  1  data memory not ready this cycle
pc_write  out  1  PC load enable
IF_ID_write  out  1  IF_ID load enable
IF_ID_flush  out  1  IF_ID loads a nop
ID_EXE_write  out  1  ID_EXE load enable
ID_EXE_bubble  out  1  ID_EXE loads all-zero control fields
pipe_freeze  out  1  EXE_MEM and MEM_WB hold
state  out  2  FSM state: RUN=0, LOAD_STALL=1, MEM_WAIT=2, FLUSH=3
stall_count  out  CNT_W  cycles with pc_write=0, saturating
flush_count  out  CNT_W  cycles with IF_ID_flush=1, saturating
mem_timeout  out  1  sticky memory-timeout error

Behaviour:
- Control outputs are combinational from state and inputs. The state, counters and mem_timeout are registered.
- While rst=1, control outputs take their default values regardless of inputs:
  - pc_write=1, IF_ID_write=1, ID_EXE_write=1
  - IF_ID_flush=0, ID_EXE_bubble=0, pipe_freeze=0
- After the reset edge: state=RUN, stall_count=0, flush_count=0, mem_timeout=0, internal busy counter=0.
- Hazard term: lu = EXE_mem_read && EXE_reg_address_rt!=0 && (EXE_reg_address_rt==ID_reg_address_rs || (ID_uses_rt && EXE_reg_address_rt==ID_reg_address_rt)). Register $0 never hazards.
- Conditions are evaluated in priority order each cycle, from any state:
  1. mem_busy=1 (freeze): pc_write=0, IF_ID_write=0, ID_EXE_write=0, pipe_freeze=1, no flush, no bubble. Next state is MEM_WAIT.
  2. lu=1 (load-use): pc_write=0, IF_ID_write=0, ID_EXE_bubble=1, ID_EXE_write=1. branch_taken and jump are ignored this cycle because the ID operands are stale. Next state is LOAD_STALL.
  3. (branch_taken||jump) and state!=FLUSH: IF_ID_flush=1, pc_write=1, IF_ID_write=1. Next state is FLUSH.
  4. Otherwise: default enables. Next state is RUN.
- In FLUSH, branch_taken and jump are masked because ID holds a nop; the state returns to RUN next cycle unless rule 1 or 2 fires.
- In LOAD_STALL, lu re-evaluates against the bubble in EXE. A second consecutive stall occurs only if the inputs genuinely hazard again.
- In MEM_WAIT, the pipeline stays frozen while mem_busy=1. When mem_busy falls, rules 2-4 apply in that same cycle. A load held in EXE during the freeze is re-checked once it advances.
- Counters:
  - stall_count increments on every clock edge where pc_write=0, including freeze cycles.
  - flush_count increments on every edge where IF_ID_flush=1.
  - Both hold at 2^CNT_W-1.
- Timeout:
  - The busy counter increments each cycle mem_busy=1 and clears when mem_busy=0.
  - mem_timeout sets on the edge that completes MEM_TIMEOUT consecutive busy cycles.
  - Once set, mem_timeout stays 1 until rst. The freeze itself is unaffected.
- Reset mid-stall or mid-freeze: the next edge returns all state to the reset values above. No partial stall carries over.

Test Plan:
1. EXE_mem_read=1, EXE rt=5, ID rs=5 for 1 cycle -> that cycle: pc_write=0, IF_ID_write=0, ID_EXE_bubble=1; state=1 next; stall_count=1.
2. Same as 1 but EXE rt=0, or a match only on rt with ID_uses_rt=0 -> no stall, all enables 1, stall_count=0.
3. branch_taken=1 for 2 consecutive cycles from RUN -> IF_ID_flush=1 in cycle 1 only, state=3 then 0, flush_count=1.
4. mem_busy=1 for 3 cycles with lu=1 and branch_taken=1 also asserted -> pipe_freeze=1 and ID_EXE_write=0 for 3 cycles, no bubble or flush; stall_count=3; in the 4th cycle the load-use stall asserts.
5. MEM_TIMEOUT=4: mem_busy high 3 cycles, low 1, high 4 -> mem_timeout=0 after the first burst, 1 after the 4th edge of the second burst, stays 1 until rst.
6. CNT_W=3: 9 load-use stalls, then rst asserted during a freeze -> stall_count saturates at 7; after the reset edge counters=0, state=0, enables=1.

Source files
------------

// File: rtl/hazard_stall_ctrl_if.sv
// Pipeline hazard bus: ID/EXE hazard sources and memory status in, stage enables/flush/bubble/freeze
// and performance/status observables out. master = pipeline side, slave = stall controller.
interface hazard_stall_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       ID_reg_address_rs;
  logic [4:0]       ID_reg_address_rt;
  logic             ID_uses_rt;
  logic             EXE_mem_read;
  logic [4:0]       EXE_reg_address_rt;
  logic             branch_taken;
  logic             jump;
  logic             mem_busy;
  logic             pc_write;
  logic             IF_ID_write;
  logic             IF_ID_flush;
  logic             ID_EXE_write;
  logic             ID_EXE_bubble;
  logic             pipe_freeze;
  logic [1:0]       state;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] flush_count;
  logic             mem_timeout;

  modport master (
    output ID_reg_address_rs, ID_reg_address_rt, ID_uses_rt, EXE_mem_read,
           EXE_reg_address_rt, branch_taken, jump, mem_busy,
    input  pc_write, IF_ID_write, IF_ID_flush, ID_EXE_write, ID_EXE_bubble,
           pipe_freeze, state, stall_count, flush_count, mem_timeout
  );

  modport slave (
    input  ID_reg_address_rs, ID_reg_address_rt, ID_uses_rt, EXE_mem_read,
           EXE_reg_address_rt, branch_taken, jump, mem_busy,
    output pc_write, IF_ID_write, IF_ID_flush, ID_EXE_write, ID_EXE_bubble,
           pipe_freeze, state, stall_count, flush_count, mem_timeout
  );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Stall/flush sequencer: combinational stage controls from state+inputs (0 cycles), registered state/counters.
// Priority per cycle: memory freeze > load-use bubble > branch/jump flush (masked in FLUSH) > run.
module hazard_stall_ctrl #(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic                clk,
  input  logic                rst,
  hazard_stall_ctrl_if.slave  bus
);

  localparam int BW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [BW-1:0]    BUSY_SAT = BW'(MEM_TIMEOUT);
  localparam logic [BW-1:0]    BUSY_END = BW'(MEM_TIMEOUT - 1);

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    MEM_WAIT   = 2'd2,
    FLUSH      = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;
  logic [BW-1:0]    busy_q, busy_d;
  logic             timeout_q, timeout_d;

  logic lu;
  logic redirect;
  logic pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, freeze;

  // Register $0 is hardwired, so a load targeting it can never hazard.
  always_comb begin
    lu = bus.EXE_mem_read && (bus.EXE_reg_address_rt != 5'd0) &&
         ((bus.EXE_reg_address_rt == bus.ID_reg_address_rs) ||
          (bus.ID_uses_rt && (bus.EXE_reg_address_rt == bus.ID_reg_address_rt)));
    redirect = (bus.branch_taken || bus.jump) && (state_q != FLUSH);
  end

  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_write  = 1'b1;
    idex_bubble = 1'b0;
    freeze      = 1'b0;
    state_d     = RUN;
    if (rst) begin
      state_d = RUN;
    end else if (bus.mem_busy) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      idex_write = 1'b0;
      freeze     = 1'b1;
      state_d    = MEM_WAIT;
    end else if (lu) begin
      // Branch/jump outcome is ignored: the ID operands are stale until the load lands.
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
      state_d     = LOAD_STALL;
    end else if (redirect) begin
      ifid_flush = 1'b1;
      state_d    = FLUSH;
    end
  end

  always_comb begin
    stall_d   = stall_q;
    flush_d   = flush_q;
    busy_d    = '0;
    timeout_d = timeout_q;
    if (!pc_write && (stall_q != CNT_MAX)) stall_d = stall_q + 1'b1;
    if (ifid_flush && (flush_q != CNT_MAX)) flush_d = flush_q + 1'b1;
    if (bus.mem_busy) begin
      busy_d = (busy_q == BUSY_SAT) ? busy_q : busy_q + 1'b1;
      if (busy_q == BUSY_END) timeout_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RUN;
      stall_q   <= '0;
      flush_q   <= '0;
      busy_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      stall_q   <= stall_d;
      flush_q   <= flush_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.pc_write      = pc_write;
  assign bus.IF_ID_write   = ifid_write;
  assign bus.IF_ID_flush   = ifid_flush;
  assign bus.ID_EXE_write  = idex_write;
  assign bus.ID_EXE_bubble = idex_bubble;
  assign bus.pipe_freeze   = freeze;
  assign bus.state         = state_q;
  assign bus.stall_count   = stall_q;
  assign bus.flush_count   = flush_q;
  assign bus.mem_timeout   = timeout_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench for hazard_stall_ctrl: stimulus pushes model expectations, a monitor pops and compares.
// Small CNT_W / MEM_TIMEOUT so saturation and timeout are reached quickly.
module tb_hazard_stall_ctrl;

  localparam int CW   = 3;
  localparam int MTO  = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hazard_stall_ctrl_if #(.CNT_W(CW)) bus ();

  hazard_stall_ctrl #(.CNT_W(CW), .MEM_TIMEOUT(MTO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ctrl order: {pc_write, IF_ID_write, IF_ID_flush, ID_EXE_write, ID_EXE_bubble, pipe_freeze}
  typedef struct {
    logic [5:0] ctrl;
    int         st;
    int         stall;
    int         flush;
    bit         to;
  } exp_t;

  exp_t sb[$];
  int compared   = 0;
  int mismatched = 0;
  int pushed     = 0;

  // Reference model: abstract mode plus plain integer tallies.
  int m_mode  = 0;
  int m_stall = 0;
  int m_flush = 0;
  int m_run   = 0;
  bit m_to    = 1'b0;

  task automatic cyc(input bit r, input int rs, input int rt, input bit urt,
                     input bit ld, input int ert, input bit br, input bit jp, input bit mb);
    exp_t e;
    bit   hz;
    @(negedge clk);
    rst                    = r;
    bus.ID_reg_address_rs  = 5'(rs);
    bus.ID_reg_address_rt  = 5'(rt);
    bus.ID_uses_rt         = urt;
    bus.EXE_mem_read       = ld;
    bus.EXE_reg_address_rt = 5'(ert);
    bus.branch_taken       = br;
    bus.jump               = jp;
    bus.mem_busy           = mb;

    hz = ld && ert != 0 && (ert == rs || (urt && ert == rt));
    if (r) begin
      e.ctrl = 6'b110100;
      m_mode = 0; m_stall = 0; m_flush = 0; m_run = 0; m_to = 0;
    end else begin
      if (mb)                               begin e.ctrl = 6'b000001; m_mode = 2; end
      else if (hz)                          begin e.ctrl = 6'b000110; m_mode = 1; end
      else if ((br || jp) && m_mode != 3)   begin e.ctrl = 6'b111100; m_mode = 3; end
      else                                  begin e.ctrl = 6'b110100; m_mode = 0; end
      if (!e.ctrl[5]) m_stall = (m_stall + 1 > CMAX) ? CMAX : m_stall + 1;
      if (e.ctrl[3])  m_flush = (m_flush + 1 > CMAX) ? CMAX : m_flush + 1;
      m_run = mb ? m_run + 1 : 0;
      if (m_run >= MTO) m_to = 1'b1;
    end
    e.st = m_mode; e.stall = m_stall; e.flush = m_flush; e.to = m_to;
    sb.push_back(e);
    pushed++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 1, 2, 1, 0, 0, 0, 0, 0);
  endtask

  // Monitor: combinational controls just after the inputs settle, registers just after the edge.
  initial begin : monitor
    exp_t e;
    logic [5:0] got;
    forever begin
      @(negedge clk);
      #2;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        got = {bus.pc_write, bus.IF_ID_write, bus.IF_ID_flush,
               bus.ID_EXE_write, bus.ID_EXE_bubble, bus.pipe_freeze};
        compared++;
        if (got !== e.ctrl) begin
          mismatched++;
          $display("FAIL ctrl t=%0t got=%b want=%b", $time, got, e.ctrl);
        end
        @(posedge clk);
        #1;
        compared++;
        if (bus.state !== 2'(e.st)) begin
          mismatched++;
          $display("FAIL state t=%0t got=%0d want=%0d", $time, bus.state, e.st);
        end
        compared++;
        if (bus.stall_count !== CW'(e.stall)) begin
          mismatched++;
          $display("FAIL stall_count t=%0t got=%0d want=%0d", $time, bus.stall_count, e.stall);
        end
        compared++;
        if (bus.flush_count !== CW'(e.flush)) begin
          mismatched++;
          $display("FAIL flush_count t=%0t got=%0d want=%0d", $time, bus.flush_count, e.flush);
        end
        compared++;
        if (bus.mem_timeout !== e.to) begin
          mismatched++;
          $display("FAIL mem_timeout t=%0t got=%0b want=%0b", $time, bus.mem_timeout, e.to);
        end
      end
    end
  end

  initial begin : stim
    bit prev_mb;
    bit mb;
    bus.ID_reg_address_rs  = '0;
    bus.ID_reg_address_rt  = '0;
    bus.ID_uses_rt         = 1'b0;
    bus.EXE_mem_read       = 1'b0;
    bus.EXE_reg_address_rt = '0;
    bus.branch_taken       = 1'b0;
    bus.jump               = 1'b0;
    bus.mem_busy           = 1'b0;

    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    // Single load-use on rs
    cyc(0, 5, 0, 0, 1, 5, 0, 0, 0);
    idle(1);
    // $0 never hazards; rt-only match ignored when rt is not a source
    cyc(0, 0, 0, 1, 1, 0, 0, 0, 0);
    cyc(0, 1, 5, 0, 1, 5, 0, 0, 0);
    cyc(0, 1, 5, 1, 1, 5, 0, 0, 0);
    idle(1);
    // Two back-to-back taken branches: only the first flushes
    cyc(0, 1, 2, 1, 0, 0, 1, 0, 0);
    cyc(0, 1, 2, 1, 0, 0, 1, 0, 0);
    cyc(0, 1, 2, 1, 0, 0, 0, 1, 0);
    idle(1);
    // Freeze dominates load-use and branch, then load-use fires
    for (int i = 0; i < 3; i++) cyc(0, 7, 0, 0, 1, 7, 1, 0, 1);
    cyc(0, 7, 0, 0, 1, 7, 1, 0, 0);
    idle(1);
    // Timeout: busy 3, gap 1, busy 4, then sticky until reset
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 1, 2, 1, 0, 0, 0, 0, 1);
    idle(1);
    for (int i = 0; i < 4; i++) cyc(0, 1, 2, 1, 0, 0, 0, 0, 1);
    idle(3);
    // Stall counter saturation, then reset mid-freeze
    for (int i = 0; i < 9; i++) cyc(0, 3, 0, 0, 1, 3, 0, 0, 0);
    cyc(0, 1, 2, 1, 0, 0, 0, 0, 1);
    cyc(1, 3, 0, 0, 1, 3, 1, 0, 1);
    idle(2);

    prev_mb = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      mb = ($urandom_range(0, 99) < (prev_mb ? 75 : 12));
      prev_mb = mb;
      cyc(($urandom_range(0, 199) == 0),
          $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1),
          $urandom_range(0, 1), $urandom_range(0, 3),
          ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0), mb);
    end

    repeat (3) @(negedge clk);
    compared++;
    if (sb.size() != 0 || compared < 5 * pushed) begin
      mismatched++;
      $display("FAIL drain left=%0d checked=%0d required=%0d", sb.size(), compared, 5 * pushed);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
